// File: rtl/counter_nb_cascade_pkg.sv
// Shared definitions for the cascadable N-bit mode counter.
// Mode encodings live here so the stepper, the top and any wrapper agree.
// No logic; types and a small helper only.
package counter_nb_cascade_pkg;

  typedef enum logic [1:0] {
    CNT_MODE_STEP = 2'b00,  // add STEP_BIG
    CNT_MODE_DEC  = 2'b01,  // subtract one
    CNT_MODE_INC  = 2'b10,  // add one
    CNT_MODE_LOAD = 2'b11   // parallel load from cnt_D
  } cnt_mode_e;

  // True for the three arithmetic modes, i.e. everything except a parallel load.
  function automatic logic is_count_mode(input logic [1:0] mode);
    return mode != CNT_MODE_LOAD;
  endfunction

endpackage

// File: rtl/counter_nb_stepper.sv
// Combinational next-value generator for one counter stage.
// Latency 0: next_q/wrap_flag follow q and mode directly.
// No flow control; the caller decides whether next_q is taken.
module counter_nb_stepper
  import counter_nb_cascade_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int STEP_BIG = 3,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] q,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] next_q,
  output logic             wrap_flag
);

  // One extra bit so the carry out of the top bit is visible as overflow.
  localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP_BIG);
  localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);

  logic [WIDTH:0] sum;
  logic           ovf;
  logic           udf;

  // Widened arithmetic per mode, then wrap or clamp the result.
  always_comb begin
    sum = {1'b0, q};
    ovf = 1'b0;
    udf = 1'b0;
    case (cnt_mode_e'(mode))
      CNT_MODE_STEP: begin
        sum = {1'b0, q} + STEP_EXT;
        ovf = sum[WIDTH];
      end
      CNT_MODE_INC: begin
        sum = {1'b0, q} + ONE_EXT;
        ovf = sum[WIDTH];
      end
      CNT_MODE_DEC: begin
        sum = {1'b0, q} - ONE_EXT;
        udf = (q == '0);
      end
      default: begin
        sum = {1'b0, q};
      end
    endcase

    wrap_flag = ovf | udf;

    if ((SATURATE != 0) && ovf) begin
      next_q = '1;
    end else if ((SATURATE != 0) && udf) begin
      next_q = '0;
    end else begin
      next_q = sum[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/counter_nb_cascade.sv
// Cascadable N-bit up/down/step/load counter with wrap or saturate.
// Latency 1 cycle from inputs to cnt_Q/cnt_load/cnt_rco; cnt_co is combinational.
// No backpressure; cnt_ci=0 freezes the count, cnt_co feeds the next stage's cnt_ci.
module counter_nb_cascade
  import counter_nb_cascade_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int STEP_BIG = 3,
  parameter int SATURATE = 0
) (
  input  logic             cnt_clk,
  input  logic             cnt_reset,
  input  logic             cnt_enable,
  input  logic             cnt_ci,
  input  logic [1:0]       cnt_mode,
  input  logic [WIDTH-1:0] cnt_D,
  output logic [WIDTH-1:0] cnt_Q,
  output logic             cnt_load,
  output logic             cnt_rco,
  output logic             cnt_co
);

  // A clamped stage never passes a carry upward.
  localparam logic CO_ALLOWED = (SATURATE == 0);

  logic [WIDTH-1:0] next_q;
  logic             wrap_flag;

  counter_nb_stepper #(
    .WIDTH    (WIDTH),
    .STEP_BIG (STEP_BIG),
    .SATURATE (SATURATE)
  ) u_stepper (
    .q         (cnt_Q),
    .mode      (cnt_mode),
    .next_q    (next_q),
    .wrap_flag (wrap_flag)
  );

  // Look-ahead carry: asserted when this edge will wrap, so the next stage steps on the same edge.
  assign cnt_co = CO_ALLOWED & cnt_reset & cnt_enable & cnt_ci
                & is_count_mode(cnt_mode) & wrap_flag;

  // Count/load/rco registers; priority is reset, disable, load, ci gating, count.
  always_ff @(posedge cnt_clk or negedge cnt_reset) begin
    if (!cnt_reset) begin
      cnt_Q    <= '0;
      cnt_load <= 1'b0;
      cnt_rco  <= 1'b0;
    end else if (!cnt_enable) begin
      cnt_Q    <= '0;
      cnt_load <= 1'b0;
      cnt_rco  <= 1'b0;
    end else if (!is_count_mode(cnt_mode)) begin
      cnt_Q    <= cnt_D;
      cnt_load <= 1'b1;
      cnt_rco  <= 1'b0;
    end else if (cnt_ci) begin
      cnt_Q    <= next_q;
      cnt_load <= 1'b0;
      cnt_rco  <= wrap_flag;
    end else begin
      cnt_load <= 1'b0;
      cnt_rco  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_nb_cascade.sv
// Bench for counter_nb_cascade: wrap and saturate 4-bit counters sharing stimulus,
// plus a two-stage 8-bit cascade, checked every cycle against an integer model
// and at key points against hand-computed values.
module tb_counter_nb_cascade;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en, ci;
  logic [1:0] mode;
  logic [3:0] d;
  logic       c_en, c_ci;
  logic [1:0] c_mode;
  logic [7:0] c_d;

  logic [3:0] q, sq, q0, q1;
  logic       load, rco, co, sload, srco, sco;
  logic       load0, rco0, co0, load1, rco1, co1;

  int  chk_cnt  = 0;
  int  pass_cnt = 0;
  bit  run      = 1'b0;

  always #5 clk = ~clk;

  counter_nb_cascade #(.WIDTH(4), .STEP_BIG(3), .SATURATE(0)) dut (
    .cnt_clk(clk), .cnt_reset(rst), .cnt_enable(en), .cnt_ci(ci), .cnt_mode(mode),
    .cnt_D(d), .cnt_Q(q), .cnt_load(load), .cnt_rco(rco), .cnt_co(co));

  counter_nb_cascade #(.WIDTH(4), .STEP_BIG(3), .SATURATE(1)) dut_sat (
    .cnt_clk(clk), .cnt_reset(rst), .cnt_enable(en), .cnt_ci(ci), .cnt_mode(mode),
    .cnt_D(d), .cnt_Q(sq), .cnt_load(sload), .cnt_rco(srco), .cnt_co(sco));

  counter_nb_cascade #(.WIDTH(4), .STEP_BIG(3), .SATURATE(0)) stage0 (
    .cnt_clk(clk), .cnt_reset(rst), .cnt_enable(c_en), .cnt_ci(c_ci), .cnt_mode(c_mode),
    .cnt_D(c_d[3:0]), .cnt_Q(q0), .cnt_load(load0), .cnt_rco(rco0), .cnt_co(co0));

  counter_nb_cascade #(.WIDTH(4), .STEP_BIG(1), .SATURATE(0)) stage1 (
    .cnt_clk(clk), .cnt_reset(rst), .cnt_enable(c_en), .cnt_ci(co0), .cnt_mode(c_mode),
    .cnt_D(c_d[7:4]), .cnt_Q(q1), .cnt_load(load1), .cnt_rco(rco1), .cnt_co(co1));

  task automatic check(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Plain arithmetic result of one count operation (unbounded integer).
  function automatic int apply(input int val, input int md, input int stp);
    case (md)
      0:       return val + stp;
      1:       return val - 1;
      2:       return val + 1;
      default: return val;
    endcase
  endfunction

  function automatic bit oor(input int r, input int lim);
    return (r < 0) || (r > lim);
  endfunction

  // Model state: standalone wrap/saturate counters and the 8-bit cascade value.
  int m_q = 0, s_q = 0, c_v = 0;
  bit m_load = 0, m_rco = 0, s_load = 0, s_rco = 0;
  bit c_load = 0, c_rco_lo = 0, c_rco_hi = 0;

  always @(posedge clk or negedge rst) begin : model
    int r, rs, rl, rc;
    if (!rst) begin
      m_q = 0; m_load = 0; m_rco = 0;
      s_q = 0; s_load = 0; s_rco = 0;
      c_v = 0; c_load = 0; c_rco_lo = 0; c_rco_hi = 0;
    end else begin
      if (!en) begin
        m_q = 0; m_load = 0; m_rco = 0;
        s_q = 0; s_load = 0; s_rco = 0;
      end else if (mode == 2'b11) begin
        m_q = int'(d); m_load = 1; m_rco = 0;
        s_q = int'(d); s_load = 1; s_rco = 0;
      end else if (!ci) begin
        m_load = 0; m_rco = 0; s_load = 0; s_rco = 0;
      end else begin
        r  = apply(m_q, int'(mode), 3);
        m_rco = oor(r, 15); m_q = (r + 16) % 16; m_load = 0;
        rs = apply(s_q, int'(mode), 3);
        s_rco = oor(rs, 15); s_q = (rs > 15) ? 15 : ((rs < 0) ? 0 : rs); s_load = 0;
      end
      if (!c_en) begin
        c_v = 0; c_load = 0; c_rco_lo = 0; c_rco_hi = 0;
      end else if (c_mode == 2'b11) begin
        c_v = int'(c_d); c_load = 1; c_rco_lo = 0; c_rco_hi = 0;
      end else if (!c_ci) begin
        c_load = 0; c_rco_lo = 0; c_rco_hi = 0;
      end else begin
        rc = apply(c_v, int'(c_mode), 3);
        rl = apply(c_v % 16, int'(c_mode), 3);
        c_rco_lo = oor(rl, 15); c_rco_hi = oor(rc, 255);
        c_v = (rc + 256) % 256; c_load = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (run) begin
      check("q",     int'(q),     m_q);
      check("load",  int'(load),  int'(m_load));
      check("rco",   int'(rco),   int'(m_rco));
      check("co",    int'(co),    int'(rst & en & ci & (mode != 2'b11)
                                       & oor(apply(m_q, int'(mode), 3), 15)));
      check("sat_q",    int'(sq),    s_q);
      check("sat_load", int'(sload), int'(s_load));
      check("sat_rco",  int'(srco),  int'(s_rco));
      check("sat_co",   int'(sco),   0);
      check("cas_q",    int'({q1, q0}), c_v);
      check("cas_load0", int'(load0), int'(c_load));
      check("cas_load1", int'(load1), int'(c_load));
      check("cas_rco0",  int'(rco0),  int'(c_rco_lo));
      check("cas_rco1",  int'(rco1),  int'(c_rco_hi));
      check("cas_co0",   int'(co0),   int'(rst & c_en & c_ci & (c_mode != 2'b11)
                                         & oor(apply(c_v % 16, int'(c_mode), 3), 15)));
      check("cas_co1",   int'(co1),   int'(rst & c_en & c_ci & (c_mode != 2'b11)
                                         & oor(apply(c_v, int'(c_mode), 3), 255)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    en = 1; ci = 1; mode = 2'b10; d = 0;
    c_en = 1; c_ci = 1; c_mode = 2'b10; c_d = 0;
    #1 rst = 1'b0;
    run = 1'b1;
    #1;
    check("reset_q", int'(q), 0);
    check("reset_load", int'(load), 0);
    check("reset_rco", int'(rco), 0);
    tick();
    rst = 1'b1;

    // Async reset mid-count at Q=7, held for two cycles.
    mode = 2'b11; d = 4'd5; tick();
    check("load5_q", int'(q), 5); check("load5_pulse", int'(load), 1);
    mode = 2'b10; tick(); tick();
    check("inc_to_7", int'(q), 7);
    #2 rst = 1'b0; #1;
    check("async_q", int'(q), 0); check("async_load", int'(load), 0);
    check("async_rco", int'(rco), 0);
    tick(); tick();
    check("rst_hold_q", int'(q), 0);
    rst = 1'b1;

    // Load 14 then increment through the wrap; saturating twin clamps.
    mode = 2'b11; d = 4'd14; tick();
    check("load14_q", int'(q), 14); check("load14_pulse", int'(load), 1);
    mode = 2'b10; #1;
    check("co_at_14", int'(co), 0);
    tick();
    check("q15", int'(q), 15); check("q15_load", int'(load), 0);
    #1 check("co_at_15", int'(co), 1); check("sat_co_at_15", int'(sco), 0);
    tick();
    check("wrap_q0", int'(q), 0); check("wrap_rco", int'(rco), 1);
    check("sat_hold15", int'(sq), 15); check("sat_rco1", int'(srco), 1);
    tick();
    check("q1", int'(q), 1); check("q1_rco", int'(rco), 0);
    check("sat_hold15b", int'(sq), 15); check("sat_rco2", int'(srco), 1);

    // Big step and down-count borrow.
    mode = 2'b11; d = 4'd12; tick();
    mode = 2'b00; tick();
    check("step_15", int'(q), 15); check("step_15_rco", int'(rco), 0);
    tick();
    check("step_wrap2", int'(q), 2); check("step_wrap_rco", int'(rco), 1);
    mode = 2'b11; d = 4'd0; tick();
    mode = 2'b01; #1;
    check("co_borrow", int'(co), 1);
    tick();
    check("dec_wrap15", int'(q), 15); check("dec_rco", int'(rco), 1);
    check("sat_dec0", int'(sq), 0); check("sat_dec_rco", int'(srco), 1);

    // Disable beats load; re-enable loads.
    en = 0; mode = 2'b11; d = 4'd9; tick();
    check("dis_q", int'(q), 0); check("dis_load", int'(load), 0);
    en = 1; tick();
    check("reen_q", int'(q), 9); check("reen_load", int'(load), 1);

    // Two-stage cascade.
    c_mode = 2'b11; c_d = 8'h0E; tick();
    check("cas_load0E", int'({q1, q0}), 14); check("cas_load_pulse", int'(load1), 1);
    c_mode = 2'b10; tick();
    check("cas_0F", int'({q1, q0}), 15);
    tick();
    check("cas_10", int'({q1, q0}), 16); check("cas_10_rco1", int'(rco1), 0);
    c_mode = 2'b11; c_d = 8'hFE; tick();
    c_mode = 2'b10; tick();
    check("cas_FF", int'({q1, q0}), 255);
    #1 check("cas_co1_at_FF", int'(co1), 1);
    tick();
    check("cas_00", int'({q1, q0}), 0); check("cas_rco1", int'(rco1), 1);
    check("cas_rco0", int'(rco0), 1);
    tick();
    check("cas_01", int'({q1, q0}), 1);
    c_ci = 0; tick(); tick();
    check("cas_freeze", int'({q1, q0}), 1); check("cas_freeze_rco1", int'(rco1), 0);

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      en     = ($urandom_range(0, 15) != 0);
      ci     = ($urandom_range(0, 3) != 0);
      mode   = 2'($urandom_range(0, 3));
      d      = 4'($urandom);
      c_en   = ($urandom_range(0, 15) != 0);
      c_ci   = ($urandom_range(0, 3) != 0);
      c_mode = 2'($urandom_range(0, 3));
      c_d    = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 63) == 0) begin
        #2 rst = 1'b0;
      end
      tick();
    end

    run = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
